// File: rtl/qkv_rd_pkg.sv
// Shared types and constants for the Q/K/V line-store read sequencer.
// Line bundle carried through the skid FIFO lives here too.
package qkv_rd_pkg;

  localparam int SPIKE_W = 128;
  localparam int DEPTH   = 768;
  localparam int ADDR_W  = 10;
  localparam int LEN_W   = 11;

  typedef enum logic [1:0] {
    SEL_Q   = 2'd0,
    SEL_K   = 2'd1,
    SEL_V   = 2'd2,
    SEL_RSV = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_STREAM   = 2'd2,
    ST_DRAIN    = 2'd3
  } state_e;

  typedef struct packed {
    logic [SPIKE_W-1:0] data;
    logic [ADDR_W-1:0]  idx;
    logic               last;
  } line_t;

  function automatic logic [ADDR_W-1:0] addr_inc(
    input logic [ADDR_W-1:0] a
  );
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_fold(
    input logic [ADDR_W-1:0] a
  );
    return (a >= ADDR_W'(DEPTH)) ? a - ADDR_W'(DEPTH) : a;
  endfunction

endpackage

// File: rtl/qkv_rd_fifo2.sv
// Two-entry first-word-fall-through skid buffer for streamed lines.
// Head entry stays put until popped, so a stalled consumer sees stable data.
module qkv_rd_fifo2
  import qkv_rd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  line_t      wdata,
  input  logic       pop,
  output line_t      rdata,
  output logic [1:0] count,
  output logic       valid
);

  line_t      mem_q [2];
  line_t      mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop && (cnt_q != 2'd0);
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = cnt_q;
  assign valid = (cnt_q != 2'd0);

endmodule

// File: rtl/qkv_ram_stream_reader.sv
// Sequences reads of one Q/K/V matrix over a wrapped line range and
// streams the lines out over valid/ready with a 2-entry skid FIFO.
module qkv_ram_stream_reader
  import qkv_rd_pkg::*;
(
  input  logic               s_clk,
  input  logic               s_rst,
  input  logic               i_SpikesTmpRam_Ready,
  input  logic               i_rd_start,
  input  logic [1:0]         i_rd_sel,
  input  logic [ADDR_W-1:0]  i_rd_base,
  input  logic [LEN_W-1:0]   i_rd_len,
  output logic               o_rd_busy,
  output logic               o_rd_done,
  output logic [ADDR_W-1:0]  o_QueryRam_rdaddr,
  output logic [ADDR_W-1:0]  o_KeyRam_rdaddr,
  output logic [ADDR_W-1:0]  o_ValueRam_rdaddr,
  input  logic [SPIKE_W-1:0] i_QueryRam_out,
  input  logic [SPIKE_W-1:0] i_KeyRam_out,
  input  logic [SPIKE_W-1:0] i_ValueRam_out,
  output logic [SPIKE_W-1:0] o_line_data,
  output logic               o_line_valid,
  input  logic               i_line_ready,
  output logic               o_line_last,
  output logic [ADDR_W-1:0]  o_line_idx
);

  state_e            state_q, state_d;
  sel_e              sel_q, sel_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] qaddr_q, qaddr_d;
  logic [ADDR_W-1:0] kaddr_q, kaddr_d;
  logic [ADDR_W-1:0] vaddr_q, vaddr_d;
  logic              infl_q, infl_d;
  logic [ADDR_W-1:0] infl_idx_q, infl_idx_d;
  logic              infl_last_q, infl_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  line_t             head;
  line_t             wline;
  logic [1:0]        fifo_cnt;
  logic              fifo_valid;
  logic              pop;
  logic [2:0]        occ;
  logic [SPIKE_W-1:0] rd_data;

  assign pop = fifo_valid && i_line_ready;
  assign occ = 3'(fifo_cnt) + 3'(infl_q) - 3'(pop);

  always_comb begin
    rd_data = '0;
    unique case (sel_q)
      SEL_Q:   rd_data = i_QueryRam_out;
      SEL_K:   rd_data = i_KeyRam_out;
      SEL_V:   rd_data = i_ValueRam_out;
      default: rd_data = '0;
    endcase
  end

  assign wline = '{data: rd_data, idx: infl_idx_q, last: infl_last_q};

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    len_d       = len_q;
    issued_d    = issued_q;
    cur_d       = cur_q;
    qaddr_d     = qaddr_q;
    kaddr_d     = kaddr_q;
    vaddr_d     = vaddr_q;
    infl_d      = 1'b0;
    infl_idx_d  = infl_idx_q;
    infl_last_d = infl_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_rd_start) begin
          sel_d    = sel_e'(i_rd_sel);
          len_d    = i_rd_len;
          issued_d = '0;
          cur_d    = addr_fold(i_rd_base);
          busy_d   = 1'b1;
          if (i_rd_len == '0 || sel_e'(i_rd_sel) == SEL_RSV)
            state_d = ST_DRAIN;
          else if (!i_SpikesTmpRam_Ready)
            state_d = ST_WAIT_RDY;
          else
            state_d = ST_STREAM;
        end
      end
      ST_WAIT_RDY: begin
        if (i_SpikesTmpRam_Ready) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        // Keep FIFO plus the one read in flight within two lines.
        if (occ < 3'd2) begin
          unique case (sel_q)
            SEL_Q:   qaddr_d = cur_q;
            SEL_K:   kaddr_d = cur_q;
            SEL_V:   vaddr_d = cur_q;
            default: ;
          endcase
          cur_d       = addr_inc(cur_q);
          issued_d    = issued_q + LEN_W'(1);
          infl_d      = 1'b1;
          infl_idx_d  = issued_q[ADDR_W-1:0];
          infl_last_d = (issued_q == len_q - LEN_W'(1));
          if (issued_q + LEN_W'(1) == len_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!infl_q && (fifo_cnt == 2'd0 ||
                        (fifo_cnt == 2'd1 && pop))) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_clk) begin
    if (!s_rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= SEL_Q;
      len_q       <= '0;
      issued_q    <= '0;
      cur_q       <= '0;
      qaddr_q     <= '0;
      kaddr_q     <= '0;
      vaddr_q     <= '0;
      infl_q      <= 1'b0;
      infl_idx_q  <= '0;
      infl_last_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      cur_q       <= cur_d;
      qaddr_q     <= qaddr_d;
      kaddr_q     <= kaddr_d;
      vaddr_q     <= vaddr_d;
      infl_q      <= infl_d;
      infl_idx_q  <= infl_idx_d;
      infl_last_q <= infl_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  qkv_rd_fifo2 u_fifo (
    .clk   (s_clk),
    .rst_n (s_rst),
    .push  (infl_q),
    .wdata (wline),
    .pop   (pop),
    .rdata (head),
    .count (fifo_cnt),
    .valid (fifo_valid)
  );

  assign o_rd_busy         = busy_q;
  assign o_rd_done         = done_q;
  assign o_QueryRam_rdaddr = qaddr_q;
  assign o_KeyRam_rdaddr   = kaddr_q;
  assign o_ValueRam_rdaddr = vaddr_q;
  assign o_line_data       = head.data;
  assign o_line_idx        = head.idx;
  assign o_line_last       = head.last;
  assign o_line_valid      = fifo_valid;

endmodule

// File: tb/tb_qkv_ram_stream_reader.sv
// Randomized scoreboard bench for the Q/K/V line-store read sequencer.
// Expected beats come from a plain array model of the three matrices.
module tb_qkv_ram_stream_reader;
  import qkv_rd_pkg::*;

  logic               s_clk = 1'b0;
  logic               s_rst = 1'b0;
  logic               i_SpikesTmpRam_Ready = 1'b1;
  logic               i_rd_start = 1'b0;
  logic [1:0]         i_rd_sel = '0;
  logic [ADDR_W-1:0]  i_rd_base = '0;
  logic [LEN_W-1:0]   i_rd_len = '0;
  logic               o_rd_busy, o_rd_done;
  logic [ADDR_W-1:0]  o_QueryRam_rdaddr, o_KeyRam_rdaddr, o_ValueRam_rdaddr;
  logic [SPIKE_W-1:0] i_QueryRam_out, i_KeyRam_out, i_ValueRam_out;
  logic [SPIKE_W-1:0] o_line_data;
  logic               o_line_valid, o_line_last;
  logic               i_line_ready = 1'b1;
  logic [ADDR_W-1:0]  o_line_idx;

  always #5 s_clk = ~s_clk;

  qkv_ram_stream_reader dut (
    .s_clk(s_clk), .s_rst(s_rst),
    .i_SpikesTmpRam_Ready(i_SpikesTmpRam_Ready),
    .i_rd_start(i_rd_start), .i_rd_sel(i_rd_sel),
    .i_rd_base(i_rd_base), .i_rd_len(i_rd_len),
    .o_rd_busy(o_rd_busy), .o_rd_done(o_rd_done),
    .o_QueryRam_rdaddr(o_QueryRam_rdaddr),
    .o_KeyRam_rdaddr(o_KeyRam_rdaddr),
    .o_ValueRam_rdaddr(o_ValueRam_rdaddr),
    .i_QueryRam_out(i_QueryRam_out),
    .i_KeyRam_out(i_KeyRam_out),
    .i_ValueRam_out(i_ValueRam_out),
    .o_line_data(o_line_data), .o_line_valid(o_line_valid),
    .i_line_ready(i_line_ready), .o_line_last(o_line_last),
    .o_line_idx(o_line_idx)
  );

  logic [SPIKE_W-1:0] q_mem [DEPTH];
  logic [SPIKE_W-1:0] k_mem [DEPTH];
  logic [SPIKE_W-1:0] v_mem [DEPTH];

  assign i_QueryRam_out = (int'(o_QueryRam_rdaddr) < DEPTH) ? q_mem[o_QueryRam_rdaddr] : '0;
  assign i_KeyRam_out   = (int'(o_KeyRam_rdaddr) < DEPTH) ? k_mem[o_KeyRam_rdaddr] : '0;
  assign i_ValueRam_out = (int'(o_ValueRam_rdaddr) < DEPTH) ? v_mem[o_ValueRam_rdaddr] : '0;

  typedef struct {
    logic [SPIKE_W-1:0] data;
    int                 idx;
    bit                 last;
  } beat_t;

  beat_t exp_q [$];
  int checks = 0, errors = 0;
  int cyc = 0, dones_seen = 0, exp_dones = 0;
  int last_hs_cyc = -10, beats_seen = 0;
  bit has_beats = 0;
  int rdy_mode = 0, stall_left = 0;
  bit stall_pend = 0;
  beat_t held;

  function automatic logic [SPIKE_W-1:0] line_of(input int sel, input int a);
    if (sel == 0) return q_mem[a];
    if (sel == 1) return k_mem[a];
    return v_mem[a];
  endfunction

  task automatic tick();
    @(posedge s_clk);
    #2;
  endtask

  task automatic start_cmd(input int sel, input int base, input int len);
    beat_t b;
    has_beats  = (len > 0) && (sel != 3);
    beats_seen = 0;
    if (has_beats)
      for (int i = 0; i < len; i++) begin
        b.data = line_of(sel, (base + i) % DEPTH);
        b.idx  = i;
        b.last = (i == len - 1);
        exp_q.push_back(b);
      end
    exp_dones++;
    i_rd_sel   = 2'(sel);
    i_rd_base  = ADDR_W'(base);
    i_rd_len   = LEN_W'(len);
    i_rd_start = 1'b1;
    tick();
    i_rd_start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string nm);
    int n = 0;
    while (dones_seen < exp_dones && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (dones_seen < exp_dones) begin
      errors++;
      $display("FAIL %s timeout: dones=%0d required=%0d", nm, dones_seen, exp_dones);
      exp_dones = dones_seen;
    end
    tick();
  endtask

  task automatic check_addr_seq(input int sel, input int base, input string nm);
    int s [8];
    bit found = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge s_clk);
      s[i] = (sel == 0) ? int'(o_QueryRam_rdaddr) :
             (sel == 1) ? int'(o_KeyRam_rdaddr) : int'(o_ValueRam_rdaddr);
    end
    for (int k = 0; k < 5; k++)
      if (s[k] == base % DEPTH && s[k+1] == (base + 1) % DEPTH &&
          s[k+2] == (base + 2) % DEPTH && s[k+3] == (base + 3) % DEPTH)
        found = 1;
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s addr seq: got %0d %0d %0d %0d %0d %0d required %0d..+3 consecutive",
               nm, s[0], s[1], s[2], s[3], s[4], s[5], base);
    end
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if (o_rd_busy || o_rd_done || o_line_valid || o_line_last ||
        o_line_idx != 0 || o_line_data != 0 || o_QueryRam_rdaddr != 0 ||
        o_KeyRam_rdaddr != 0 || o_ValueRam_rdaddr != 0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b valid=%b last=%b idx=%0d q=%0d k=%0d v=%0d required all 0",
               nm, o_rd_busy, o_rd_done, o_line_valid, o_line_last, o_line_idx,
               o_QueryRam_rdaddr, o_KeyRam_rdaddr, o_ValueRam_rdaddr);
    end
  endtask

  // Consumer ready generator.
  initial forever begin
    @(posedge s_clk);
    #1;
    if (stall_left > 0) begin
      i_line_ready = 1'b0;
      stall_left--;
    end else if (rdy_mode == 1) begin
      i_line_ready = 1'($urandom_range(0, 1));
    end else begin
      i_line_ready = 1'b1;
    end
  end

  // Monitor: handshakes, stall stability, done pulses.
  always @(negedge s_clk) begin
    beat_t e;
    cyc++;
    if (!s_rst) begin
      stall_pend = 0;
    end else begin
      if (stall_pend) begin
        checks++;
        if (!o_line_valid || o_line_data != held.data ||
            int'(o_line_idx) != held.idx || o_line_last != held.last) begin
          errors++;
          $display("FAIL stall_hold: valid=%b idx=%0d last=%b required valid=1 idx=%0d last=%b",
                   o_line_valid, o_line_idx, o_line_last, held.idx, held.last);
        end
      end
      stall_pend = o_line_valid && !i_line_ready;
      held.data  = o_line_data;
      held.idx   = int'(o_line_idx);
      held.last  = o_line_last;
      if (o_line_valid && i_line_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat unexpected: idx=%0d data=%h required no beat", o_line_idx, o_line_data);
        end else begin
          e = exp_q.pop_front();
          if (o_line_data != e.data || int'(o_line_idx) != e.idx || o_line_last != e.last) begin
            errors++;
            $display("FAIL beat: got idx=%0d last=%b data=%h required idx=%0d last=%b data=%h",
                     o_line_idx, o_line_last, o_line_data, e.idx, e.last, e.data);
          end
        end
        last_hs_cyc = cyc;
        beats_seen++;
      end
      if (o_rd_done) begin
        dones_seen++;
        checks++;
        if (exp_q.size() != 0 || o_rd_busy) begin
          errors++;
          $display("FAIL done_state: pending=%0d busy=%b required pending=0 busy=0",
                   exp_q.size(), o_rd_busy);
        end
        if (has_beats) begin
          checks++;
          if (cyc != last_hs_cyc + 1) begin
            errors++;
            $display("FAIL done_timing: done at cycle %0d required %0d", cyc, last_hs_cyc + 1);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int a = 0; a < DEPTH; a++) begin
      q_mem[a] = {$urandom, $urandom, $urandom, $urandom};
      k_mem[a] = {$urandom, $urandom, $urandom, $urandom};
      v_mem[a] = {$urandom, $urandom, $urandom, $urandom};
    end
    repeat (3) tick();
    check_zero("reset_state");
    s_rst = 1'b1;
    tick();

    // Query 0..3, full-rate consumer.
    start_cmd(0, 0, 4);
    check_addr_seq(0, 0, "query_base0");
    wait_idle(50, "query_base0");

    // Key, store not ready for 10 cycles.
    i_SpikesTmpRam_Ready = 1'b0;
    n = int'(o_KeyRam_rdaddr);
    start_cmd(1, 5, 2);
    begin
      bit moved = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge s_clk);
        if (int'(o_KeyRam_rdaddr) != n || o_line_valid) moved = 1;
      end
      checks++;
      if (moved) begin
        errors++;
        $display("FAIL wait_rdy: key addr=%0d valid=%b required addr=%0d valid=0",
                 o_KeyRam_rdaddr, o_line_valid, n);
      end
    end
    tick();
    i_SpikesTmpRam_Ready = 1'b1;
    wait_idle(50, "key_wait");

    // Value wrap 766, 767, 0, 1.
    start_cmd(2, 766, 4);
    check_addr_seq(2, 766, "value_wrap");
    wait_idle(50, "value_wrap");

    // Backpressure with a long stall mid-stream.
    rdy_mode = 1;
    start_cmd(0, 300, 8);
    repeat (3) tick();
    stall_left = 5;
    wait_idle(200, "backpressure");
    rdy_mode = 0;

    // Empty commands; second start while busy ignored.
    start_cmd(0, 10, 0);
    i_rd_sel   = 2'd0;
    i_rd_len   = LEN_W'(3);
    i_rd_start = 1'b1;
    tick();
    i_rd_start = 1'b0;
    wait_idle(10, "len0");
    repeat (5) tick();
    start_cmd(3, 10, 5);
    wait_idle(10, "sel3");
    repeat (5) tick();

    // Randomized commands.
    for (int t = 0; t < 8; t++) begin
      rdy_mode = 1;
      if ($urandom_range(0, 3) == 0) i_SpikesTmpRam_Ready = 1'b0;
      start_cmd($urandom_range(0, 2), $urandom_range(0, DEPTH - 1), $urandom_range(1, 24));
      repeat ($urandom_range(0, 4)) tick();
      i_SpikesTmpRam_Ready = 1'b1;
      wait_idle(400, "random");
    end
    rdy_mode = 0;

    // Reset mid-stream.
    start_cmd(0, 100, 6);
    n = 0;
    while (beats_seen < 2 && n < 50) begin
      tick();
      n++;
    end
    s_rst = 1'b0;
    @(posedge s_clk);
    #1;
    check_zero("mid_reset");
    exp_q.delete();
    exp_dones--;
    has_beats = 0;
    tick();
    s_rst = 1'b1;
    repeat (5) tick();

    // Fresh command after abort.
    start_cmd(2, 10, 3);
    wait_idle(50, "after_reset");
    repeat (5) tick();

    checks++;
    if (dones_seen != exp_dones || exp_q.size() != 0) begin
      errors++;
      $display("FAIL final: dones=%0d pending=%0d required dones=%0d pending=0",
               dones_seen, exp_q.size(), exp_dones);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
